// File: rtl/cim_ark_sbox_responder_if.sv
// Byte-pair port between the AES core and the compute-in-memory responder.
interface cim_ark_sbox_responder_if;
    logic [15:0]  IN;
    logic         IN_VLD;
    logic         BLK_START;
    logic         KWE;
    logic [3:0]   KWADDR;
    logic [127:0] KWDATA;
    logic [7:0]   RIO_00, RIO_01, RIO_02, RIO_03;
    logic [7:0]   RIO_04, RIO_05, RIO_06, RIO_07;
    logic [7:0]   RIO_08, RIO_09, RIO_10, RIO_11;
    logic [7:0]   RIO_12, RIO_13, RIO_14, RIO_15;
    logic         RDY;
    logic         BSY;
    logic [3:0]   RND;
    logic         OVF;

    modport master (
        output IN, IN_VLD, BLK_START, KWE, KWADDR, KWDATA,
        input  RIO_00, RIO_01, RIO_02, RIO_03,
        input  RIO_04, RIO_05, RIO_06, RIO_07,
        input  RIO_08, RIO_09, RIO_10, RIO_11,
        input  RIO_12, RIO_13, RIO_14, RIO_15,
        input  RDY, BSY, RND, OVF
    );

    modport slave (
        input  IN, IN_VLD, BLK_START, KWE, KWADDR, KWDATA,
        output RIO_00, RIO_01, RIO_02, RIO_03,
        output RIO_04, RIO_05, RIO_06, RIO_07,
        output RIO_08, RIO_09, RIO_10, RIO_11,
        output RIO_12, RIO_13, RIO_14, RIO_15,
        output RDY, BSY, RND, OVF
    );
endinterface

// File: rtl/cim_ark_sbox_responder.sv
// AddRoundKey + S-box responder for the AES compute-in-memory byte port.
// Collects 8 byte pairs against key[rnd], then substitutes all 16 bytes.
module cim_ark_sbox_responder (
    input  logic                    CLK,
    input  logic                    RSTn,
    cim_ark_sbox_responder_if.slave bus
);
    typedef enum logic {COLLECT, LOOKUP} state_t;

    state_t       state, state_n;
    logic [127:0] key [11];
    logic [7:0]   ark [16];
    logic [7:0]   rio [16];
    logic [2:0]   cnt, cnt_n, kk;
    logic [3:0]   rnd, rnd_n, kidx;
    logic         ovf, ovf_n, rdy, acc, lut;
    logic [15:0]  kp;

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] s;
        s = 8'h00;
        case (a)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b;
            8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b;
            8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d;
            8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf;
            8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26;
            8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1;
            8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3;
            8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2;
            8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a;
            8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3;
            8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed;
            8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39;
            8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb;
            8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f;
            8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f;
            8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21;
            8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec;
            8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d;
            8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc;
            8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14;
            8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a;
            8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62;
            8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d;
            8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea;
            8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e;
            8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f;
            8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66;
            8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9;
            8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11;
            8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9;
            8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d;
            8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f;
            8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // BLK_START forces the accepted pair to slot 0 of key[0]
    assign kk   = bus.BLK_START ? 3'd0 : cnt;
    assign kidx = bus.BLK_START ? 4'd0 : rnd;
    assign kp   = key[kidx][{~kk, 4'b0000} +: 16];

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rnd_n   = rnd;
        ovf_n   = ovf;
        acc     = 1'b0;
        lut     = 1'b0;
        unique case (state)
            COLLECT: begin
                if (bus.IN_VLD) begin
                    acc   = 1'b1;
                    cnt_n = kk + 3'd1;
                    if (kk == 3'd7) state_n = LOOKUP;
                end
            end
            LOOKUP: begin
                lut     = 1'b1;
                cnt_n   = 3'd0;
                state_n = COLLECT;
                rnd_n   = (rnd < 4'd10) ? rnd + 4'd1 : rnd;
                if (bus.IN_VLD) ovf_n = 1'b1;
            end
            default: state_n = COLLECT;
        endcase
        if (bus.BLK_START) begin
            rnd_n = 4'd0;
            ovf_n = 1'b0;
            if (!acc) cnt_n = 3'd0;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= COLLECT;
            cnt   <= 3'd0;
            rnd   <= 4'd0;
            ovf   <= 1'b0;
            rdy   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            rnd   <= rnd_n;
            ovf   <= ovf_n;
            rdy   <= lut;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int i = 0; i < 11; i++) key[i] <= '0;
            for (int j = 0; j < 16; j++) begin
                ark[j] <= '0;
                rio[j] <= '0;
            end
        end else begin
            if (bus.KWE && bus.KWADDR <= 4'd10)
                key[bus.KWADDR] <= bus.KWDATA;
            if (acc) begin
                ark[{kk, 1'b0}] <= bus.IN[15:8] ^ kp[15:8];
                ark[{kk, 1'b1}] <= bus.IN[7:0] ^ kp[7:0];
                rio[{kk, 1'b0}] <= bus.IN[15:8] ^ kp[15:8];
                rio[{kk, 1'b1}] <= bus.IN[7:0] ^ kp[7:0];
            end
            if (lut) begin
                for (int j = 0; j < 16; j++) rio[j] <= sbox(ark[j]);
            end
        end
    end

    assign bus.RIO_00 = rio[0];
    assign bus.RIO_01 = rio[1];
    assign bus.RIO_02 = rio[2];
    assign bus.RIO_03 = rio[3];
    assign bus.RIO_04 = rio[4];
    assign bus.RIO_05 = rio[5];
    assign bus.RIO_06 = rio[6];
    assign bus.RIO_07 = rio[7];
    assign bus.RIO_08 = rio[8];
    assign bus.RIO_09 = rio[9];
    assign bus.RIO_10 = rio[10];
    assign bus.RIO_11 = rio[11];
    assign bus.RIO_12 = rio[12];
    assign bus.RIO_13 = rio[13];
    assign bus.RIO_14 = rio[14];
    assign bus.RIO_15 = rio[15];
    assign bus.RDY    = rdy;
    assign bus.BSY    = (state == LOOKUP);
    assign bus.RND    = rnd;
    assign bus.OVF    = ovf;
endmodule

// File: tb/tb_cim_ark_sbox_responder.sv
// Bench for cim_ark_sbox_responder: FIPS-197 vectors plus randomized
// blocks checked against a GF(2^8) S-box and key-expansion model.
module tb_cim_ark_sbox_responder;
    logic CLK = 1'b0;
    logic RSTn;
    always #5 CLK = ~CLK;

    cim_ark_sbox_responder_if bus();
    cim_ark_sbox_responder dut (.CLK(CLK), .RSTn(RSTn), .bus(bus));

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_SB  = 128'h63cab7040953d051cd60e0e7ba70e18c;

    int ntests = 0;
    int nfail  = 0;
    logic [7:0]   m_sb  [256];
    logic [127:0] xk    [11];
    logic [127:0] m_key [11];
    int           mr;
    bit           movf;
    logic [127:0] snap;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // multiplicative inverse followed by the affine transform
    function automatic logic [7:0] ref_sbox(input logic [7:0] a);
        logic [7:0] v = 8'h00;
        for (int c = 1; c < 256; c++)
            if (gmul(a, 8'(c)) == 8'h01) v = 8'(c);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
                 ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sbox_all(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[127-8*i -: 8] = m_sb[x[127-8*i -: 8]];
        return y;
    endfunction

    function automatic logic [127:0] rio_all();
        return {bus.RIO_00, bus.RIO_01, bus.RIO_02, bus.RIO_03,
                bus.RIO_04, bus.RIO_05, bus.RIO_06, bus.RIO_07,
                bus.RIO_08, bus.RIO_09, bus.RIO_10, bus.RIO_11,
                bus.RIO_12, bus.RIO_13, bus.RIO_14, bus.RIO_15};
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {m_sb[t[31:24]], m_sb[t[23:16]], m_sb[t[15:8]], m_sb[t[7:0]]}
                    ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++)
            xk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_keys();
        for (int r = 0; r < 11; r++) begin
            bus.KWE    = 1'b1;
            bus.KWADDR = 4'(r);
            bus.KWDATA = xk[r];
            tick();
            m_key[r] = xk[r];
        end
        bus.KWE = 1'b0;
    endtask

    task automatic blk_pulse();
        bus.BLK_START = 1'b1;
        tick();
        bus.BLK_START = 1'b0;
        mr   = 0;
        movf = 1'b0;
    endtask

    task automatic run_block(input logic [127:0] p, input int n,
                             input int gap_at, input int gap_len,
                             input bit blk0, input bit ovf,
                             input int kw_at, input logic [127:0] kwv);
        logic [127:0] ex;
        logic [127:0] r;
        ex = '0;
        if (blk0) begin
            mr   = 0;
            movf = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                bus.IN_VLD = 1'b0;
                repeat (gap_len) tick();
            end
            bus.IN        = p[127-16*k -: 16];
            bus.IN_VLD    = 1'b1;
            bus.BLK_START = blk0 && (k == 0);
            bus.KWE       = (k == kw_at);
            bus.KWADDR    = 4'(mr);
            bus.KWDATA    = kwv;
            ex[127-16*k -: 16] = p[127-16*k -: 16] ^ m_key[mr][127-16*k -: 16];
            tick();
            bus.BLK_START = 1'b0;
            bus.KWE       = 1'b0;
            if (k == kw_at) m_key[mr] = kwv;
            r = rio_all();
            chk("ark_pair", {112'h0, r[127-16*k -: 16]}, {112'h0, ex[127-16*k -: 16]});
        end
        if (n < 8) begin
            bus.IN_VLD = 1'b0;
            return;
        end
        bus.IN_VLD = ovf;
        bus.IN     = 16'($urandom);
        chk("bsy_in_lookup", 128'(bus.BSY), 128'(1));
        chk("rdy_before_lookup", 128'(bus.RDY), 128'(0));
        tick();
        bus.IN_VLD = 1'b0;
        if (ovf) movf = 1'b1;
        if (mr < 10) mr++;
        chk("sbox_result", rio_all(), sbox_all(ex));
        chk("rdy_pulse", 128'(bus.RDY), 128'(1));
        chk("bsy_after", 128'(bus.BSY), 128'(0));
        chk("rnd", 128'(bus.RND), 128'(mr));
        chk("ovf", 128'(bus.OVF), 128'(movf));
        tick();
        chk("rdy_one_cycle", 128'(bus.RDY), 128'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        RSTn          = 1'b1;
        bus.IN        = '0;
        bus.IN_VLD    = 1'b0;
        bus.BLK_START = 1'b0;
        bus.KWE       = 1'b0;
        bus.KWADDR    = '0;
        bus.KWDATA    = '0;
        for (int a = 0; a < 256; a++) m_sb[a] = ref_sbox(8'(a));
        expand(FIPS_KEY);
        for (int r = 0; r < 11; r++) m_key[r] = '0;
        mr   = 0;
        movf = 1'b0;

        #2 RSTn = 1'b0;
        #1;
        chk("reset_rio", rio_all(), 128'h0);
        chk("reset_flags", {125'h0, bus.RDY, bus.BSY, bus.OVF}, 128'h0);
        chk("reset_rnd", 128'(bus.RND), 128'h0);
        tick();
        tick();
        RSTn = 1'b1;

        load_keys();
        blk_pulse();
        run_block(FIPS_PT, 8, -1, 0, 1'b0, 1'b0, -1, '0);
        tick();
        chk("fips_round0", rio_all(), FIPS_SB);

        blk_pulse();
        run_block(FIPS_PT, 8, 4, 3, 1'b0, 1'b0, -1, '0);
        chk("fips_stall", rio_all(), FIPS_SB);

        blk_pulse();
        for (int r = 0; r < 12; r++)
            run_block(rnd128(), 8, int'($urandom_range(0, 8)),
                      int'($urandom_range(0, 3)), 1'b0, 1'b0, -1, '0);
        chk("rnd_saturated", 128'(bus.RND), 128'(10));

        run_block(rnd128(), 8, -1, 0, 1'b0, 1'b0, 3, rnd128());
        run_block(rnd128(), 8, -1, 0, 1'b1, 1'b0, -1, '0);

        blk_pulse();
        run_block(rnd128(), 5, -1, 0, 1'b0, 1'b0, -1, '0);
        snap = rio_all();
        blk_pulse();
        chk("midblk_rnd", 128'(bus.RND), 128'(0));
        chk("midblk_rio_kept", rio_all(), snap);
        run_block(FIPS_PT, 8, -1, 0, 1'b0, 1'b0, -1, '0);
        chk("midblk_fips", rio_all(), FIPS_SB);

        run_block(rnd128(), 8, -1, 0, 1'b0, 1'b1, -1, '0);
        run_block(rnd128(), 8, 2, 1, 1'b0, 1'b0, -1, '0);
        bus.KWE    = 1'b1;
        bus.KWADDR = 4'd12;
        bus.KWDATA = rnd128();
        tick();
        bus.KWE = 1'b0;
        blk_pulse();
        chk("ovf_cleared", 128'(bus.OVF), 128'(0));
        for (int r = 0; r < 11; r++)
            run_block(rnd128(), 8, -1, 0, 1'b0, 1'b0, -1, '0);

        blk_pulse();
        run_block(rnd128(), 4, -1, 0, 1'b0, 1'b0, -1, '0);
        RSTn = 1'b0;
        #1;
        chk("midrst_rio", rio_all(), 128'h0);
        chk("midrst_rnd", 128'(bus.RND), 128'h0);
        chk("midrst_flags", {125'h0, bus.RDY, bus.BSY, bus.OVF}, 128'h0);
        tick();
        RSTn = 1'b1;
        for (int r = 0; r < 11; r++) m_key[r] = '0;
        mr   = 0;
        movf = 1'b0;
        run_block(rnd128(), 8, -1, 0, 1'b0, 1'b0, -1, '0);
        load_keys();
        blk_pulse();
        run_block(FIPS_PT, 8, -1, 0, 1'b0, 1'b0, -1, '0);
        chk("post_reset_fips", rio_all(), FIPS_SB);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
